// File: rtl/dpram_pkg.sv
// dpram_pkg
// Shared definitions for the parametrised dual-port RAM:
//   RD_FIRST / WR_FIRST : read-during-write collision policies
//   state_t             : clear-sweep controller states
//   nbytes()            : number of byte lanes for a given data width
package dpram_pkg;

  localparam int RD_FIRST = 0;
  localparam int WR_FIRST = 1;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  function automatic int nbytes(input int dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/dpram_clr_seq.sv
// dpram_clr_seq
// Post-reset memory-clear controller: a two-state CLEAR/RUN FSM with a sweep
// counter that walks every address once after reset.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   busy      : high while the sweep is running (requests must be dropped)
//   clr_we    : sweep write strobe for the array
//   clr_addr  : address being zeroed by the sweep
module dpram_clr_seq
  import dpram_pkg::*;
#(
  parameter int AW           = 5,
  parameter int CLEAR_ON_RST = 1
) (
  input  logic          clk,
  input  logic          rst,
  output logic          busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  localparam logic START_BUSY = (CLEAR_ON_RST != 0) ? 1'b1 : 1'b0;

  state_t        state_r;
  logic [AW-1:0] cnt_r;
  logic          busy_r;

  // Sweep FSM: one zero-write per edge, leave CLEAR on the write of the last word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= (CLEAR_ON_RST != 0) ? CLEAR : RUN;
      cnt_r   <= {AW{1'b0}};
      busy_r  <= START_BUSY;
    end else begin
      case (state_r)
        CLEAR: begin
          cnt_r <= cnt_r + {{(AW-1){1'b0}}, 1'b1};
          if (cnt_r == {AW{1'b1}}) begin
            state_r <= RUN;
            busy_r  <= 1'b0;
          end else begin
            busy_r  <= 1'b1;
          end
        end
        RUN: begin
          cnt_r  <= {AW{1'b0}};
          busy_r <= 1'b0;
        end
        default: begin
          // Unreachable encoding: restart a clean sweep.
          state_r <= CLEAR;
          cnt_r   <= {AW{1'b0}};
          busy_r  <= 1'b1;
        end
      endcase
    end
  end

  assign busy     = busy_r;
  assign clr_we   = busy_r;
  assign clr_addr = cnt_r;

endmodule

// File: rtl/dpram_param.sv
// dpram_param
// Parametrised simple dual-port RAM (one write port, one read port, shared
// clock) with byte enables, selectable read-during-write policy, optional
// output register and a post-reset clear sweep.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   wr/waddr/d_in/be : write request, address, data, byte enables
//   rd/raddr      : read request and address
//   d_out/d_valid : read data and its one-cycle valid strobe
//   busy          : clear sweep in progress, requests are ignored
module dpram_param
  import dpram_pkg::*;
#(
  parameter int DW           = 16,
  parameter int AW           = 5,
  parameter int RD_MODE      = 0,
  parameter int OUT_REG      = 0,
  parameter int CLEAR_ON_RST = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr,
  input  logic [AW-1:0]       waddr,
  input  logic [DW-1:0]       d_in,
  input  logic [DW/8-1:0]     be,
  input  logic                rd,
  input  logic [AW-1:0]       raddr,
  output logic [DW-1:0]       d_out,
  output logic                d_valid,
  output logic                busy
);

  localparam int NB    = nbytes(DW);
  localparam int DEPTH = 1 << AW;

  if (DW % 8 != 0) begin : g_dw_check
    $error("dpram_param: DW must be a multiple of 8");
  end

  // Replace the enabled byte lanes of old_w with the matching lanes of new_w.
  function automatic logic [DW-1:0] byte_merge(input logic [DW-1:0] old_w,
                                               input logic [DW-1:0] new_w,
                                               input logic [NB-1:0] en);
    logic [DW-1:0] res;
    res = old_w;
    for (int i = 0; i < NB; i++) begin
      if (en[i]) begin
        res[8*i +: 8] = new_w[8*i +: 8];
      end
    end
    return res;
  endfunction

  logic [DW-1:0] mem_r [DEPTH];

  logic          busy_s;
  logic          clr_we_s;
  logic [AW-1:0] clr_addr_s;

  logic [DW-1:0] wr_merged_s;
  logic [DW-1:0] rdata_s;
  logic          run_wr_s;
  logic          run_rd_s;

  logic [DW-1:0] d_out_r;
  logic          d_valid_r;

  dpram_clr_seq #(
    .AW           (AW),
    .CLEAR_ON_RST (CLEAR_ON_RST)
  ) u_clr_seq (
    .clk      (clk),
    .rst      (rst),
    .busy     (busy_s),
    .clr_we   (clr_we_s),
    .clr_addr (clr_addr_s)
  );

  // Request qualification, write-lane merge and read-during-write mux.
  always_comb begin
    run_wr_s    = wr & ~busy_s & ~rst;
    run_rd_s    = rd & ~busy_s;
    wr_merged_s = byte_merge(mem_r[waddr], d_in, be);
    if (RD_MODE == RD_FIRST) begin
      rdata_s = mem_r[raddr];
    end else if (wr && (waddr == raddr)) begin
      // Write-first: bypass the word as it will look after this edge.
      rdata_s = wr_merged_s;
    end else begin
      rdata_s = mem_r[raddr];
    end
  end

  // Storage: never reset; contents come from the sweep or from writes.
  always_ff @(posedge clk) begin
    if (clr_we_s && !rst) begin
      mem_r[clr_addr_s] <= {DW{1'b0}};
    end else if (run_wr_s) begin
      mem_r[waddr] <= wr_merged_s;
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic [DW-1:0] s1_data_r;
    logic          s1_valid_r;

    // Two-stage read pipeline; d_out only moves when a valid word arrives.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s1_data_r  <= {DW{1'b0}};
        s1_valid_r <= 1'b0;
        d_out_r    <= {DW{1'b0}};
        d_valid_r  <= 1'b0;
      end else begin
        s1_valid_r <= run_rd_s;
        if (run_rd_s) begin
          s1_data_r <= rdata_s;
        end
        d_valid_r <= s1_valid_r;
        if (s1_valid_r) begin
          d_out_r <= s1_data_r;
        end
      end
    end
  end else begin : g_no_out_reg
    // Single-stage read: d_out holds its last value when no read is accepted.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        d_out_r   <= {DW{1'b0}};
        d_valid_r <= 1'b0;
      end else begin
        d_valid_r <= run_rd_s;
        if (run_rd_s) begin
          d_out_r <= rdata_s;
        end
      end
    end
  end

  assign d_out   = d_out_r;
  assign d_valid = d_valid_r;
  assign busy    = busy_s;

endmodule

// File: tb/tb_dpram_param.sv
module tb_dpram_param;

  logic        clk;
  logic        rst;
  logic        wr;
  logic [4:0]  waddr;
  logic [15:0] d_in;
  logic [1:0]  be;
  logic        rd;
  logic [4:0]  raddr;

  logic [15:0] dout [4];
  logic        dval [4];
  logic        bsy  [4];

  int total;
  int bad;
  bit chk_en;

  // instance k: RD_MODE = k%2, OUT_REG = k/2
  dpram_param #(.DW(16), .AW(5), .RD_MODE(0), .OUT_REG(0), .CLEAR_ON_RST(1)) d0 (
    .clk(clk), .rst(rst), .wr(wr), .waddr(waddr), .d_in(d_in), .be(be),
    .rd(rd), .raddr(raddr), .d_out(dout[0]), .d_valid(dval[0]), .busy(bsy[0]));
  dpram_param #(.DW(16), .AW(5), .RD_MODE(1), .OUT_REG(0), .CLEAR_ON_RST(1)) d1 (
    .clk(clk), .rst(rst), .wr(wr), .waddr(waddr), .d_in(d_in), .be(be),
    .rd(rd), .raddr(raddr), .d_out(dout[1]), .d_valid(dval[1]), .busy(bsy[1]));
  dpram_param #(.DW(16), .AW(5), .RD_MODE(0), .OUT_REG(1), .CLEAR_ON_RST(1)) d2 (
    .clk(clk), .rst(rst), .wr(wr), .waddr(waddr), .d_in(d_in), .be(be),
    .rd(rd), .raddr(raddr), .d_out(dout[2]), .d_valid(dval[2]), .busy(bsy[2]));
  dpram_param #(.DW(16), .AW(5), .RD_MODE(1), .OUT_REG(1), .CLEAR_ON_RST(1)) d3 (
    .clk(clk), .rst(rst), .wr(wr), .waddr(waddr), .d_in(d_in), .be(be),
    .rd(rd), .raddr(raddr), .d_out(dout[3]), .d_valid(dval[3]), .busy(bsy[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [15:0] m_mem [32];
  int          busy_left;
  logic [15:0] e_dout [4];
  logic        e_val  [4];
  logic        p_val  [4];
  logic [15:0] p_dat  [4];

  function automatic logic [15:0] mmerge(input logic [15:0] o, input logic [15:0] n,
                                         input logic [1:0] en);
    logic [15:0] r;
    r = o;
    if (en[0]) r[7:0]  = n[7:0];
    if (en[1]) r[15:8] = n[15:8];
    return r;
  endfunction

  task automatic model_reset();
    busy_left = 32;
    for (int k = 0; k < 4; k++) begin
      e_dout[k] = 16'h0000;
      e_val[k]  = 1'b0;
      p_val[k]  = 1'b0;
      p_dat[k]  = 16'h0000;
    end
  endtask

  // Applies one rising edge with the currently driven inputs.
  task automatic model_edge();
    logic        acc;
    logic [15:0] oldw;
    logic [15:0] neww;
    logic [15:0] v [4];
    acc  = 1'b0;
    oldw = 16'h0000;
    neww = 16'h0000;
    if (busy_left > 0) begin
      m_mem[32 - busy_left] = 16'h0000;
      busy_left = busy_left - 1;
    end else begin
      acc  = rd;
      oldw = m_mem[raddr];
      neww = (wr && waddr == raddr) ? mmerge(m_mem[waddr], d_in, be) : oldw;
      if (wr) m_mem[waddr] = mmerge(m_mem[waddr], d_in, be);
    end
    for (int k = 0; k < 4; k++) begin
      v[k] = (k % 2 == 1) ? neww : oldw;
      if (k < 2) begin
        e_val[k] = acc;
        if (acc) e_dout[k] = v[k];
      end else begin
        e_val[k] = p_val[k];
        if (p_val[k]) e_dout[k] = p_dat[k];
        p_val[k] = acc;
        if (acc) p_dat[k] = v[k];
      end
    end
  endtask

  // Compare process: every DUT output against the model on each falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 4; k++) begin
        total++;
        if (dout[k] !== e_dout[k]) begin
          bad++;
          $display("FAIL cmp_dout inst=%0d t=%0t got=%h exp=%h", k, $time, dout[k], e_dout[k]);
        end
        total++;
        if (dval[k] !== e_val[k]) begin
          bad++;
          $display("FAIL cmp_valid inst=%0d t=%0t got=%b exp=%b", k, $time, dval[k], e_val[k]);
        end
        total++;
        if (bsy[k] !== (busy_left > 0)) begin
          bad++;
          $display("FAIL cmp_busy inst=%0d t=%0t got=%b exp=%b", k, $time, bsy[k], busy_left > 0);
        end
      end
    end
  end

  task automatic check_lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (!rst) model_edge();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    wr = 1'b0; rd = 1'b0;
  endtask

  task automatic write1(input logic [4:0] a, input logic [15:0] d, input logic [1:0] b);
    wr = 1'b1; waddr = a; d_in = d; be = b; rd = 1'b0;
    step();
    wr = 1'b0;
  endtask

  // Read one address and check the held d_out of every instance.
  task automatic read_lit(input string name, input logic [4:0] a, input logic [15:0] exp);
    rd = 1'b1; raddr = a;
    step();
    rd = 1'b0;
    step();
    step();
    for (int k = 0; k < 4; k++) check_lit(name, {16'h0000, dout[k]}, {16'h0000, exp});
  endtask

  task automatic count_busy(input string name);
    int cnt;
    cnt = 0;
    while (bsy[0] && cnt < 100) begin
      cnt++;
      step();
    end
    check_lit(name, cnt, 32);
  endtask

  task automatic random_phase(input int n);
    for (int i = 0; i < n; i++) begin
      wr    = 1'($urandom_range(0, 1));
      rd    = 1'($urandom_range(0, 1));
      waddr = 5'($urandom_range(0, 7));
      raddr = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
      d_in  = 16'($urandom);
      be    = 2'($urandom_range(0, 3));
      step();
    end
    idle();
  endtask

  logic        lat_v [5][4];
  logic [15:0] lat_d [5][4];

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; wr = 1'b0; rd = 1'b0;
    waddr = 5'd0; raddr = 5'd0; d_in = 16'h0000; be = 2'b00;
    for (int i = 0; i < 32; i++) m_mem[i] = 16'h0000;
    model_reset();
    chk_en = 1'b1;
    step();
    check_lit("reset_dout", {16'h0000, dout[0]}, 32'h0);
    check_lit("reset_busy", {31'h0, bsy[0]}, 32'h1);
    step();
    rst = 1'b0;

    // Writes during the sweep must be dropped.
    wr = 1'b1; waddr = 5'd3; d_in = 16'hFFFF; be = 2'b11;
    count_busy("busy_len_first");
    idle();

    for (int a = 0; a < 32; a++) begin
      rd = 1'b1; raddr = 5'(a);
      step();
      check_lit("clear_read", {16'h0000, dout[0]}, 32'h0);
      check_lit("clear_valid", {31'h0, dval[0]}, 32'h1);
    end
    idle();
    step();
    read_lit("busy_drop", 5'd3, 16'h0000);

    // Byte enables.
    write1(5'd5, 16'hAABB, 2'b11);
    write1(5'd5, 16'h1234, 2'b01);
    read_lit("byte_en", 5'd5, 16'hAA34);

    // Collision.
    write1(5'd9, 16'hABCD, 2'b11);
    wr = 1'b1; waddr = 5'd9; d_in = 16'h2525; be = 2'b11;
    rd = 1'b1; raddr = 5'd9;
    step();
    idle();
    step();
    step();
    check_lit("coll_rf0", {16'h0, dout[0]}, {16'h0, 16'hABCD});
    check_lit("coll_wf0", {16'h0, dout[1]}, {16'h0, 16'h2525});
    check_lit("coll_rf1", {16'h0, dout[2]}, {16'h0, 16'hABCD});
    check_lit("coll_wf1", {16'h0, dout[3]}, {16'h0, 16'h2525});
    read_lit("coll_after", 5'd9, 16'h2525);

    // Latency and hold: back-to-back reads of 5, 10, 31.
    write1(5'd10, 16'h0A0A, 2'b11);
    write1(5'd31, 16'h1F1F, 2'b11);
    for (int s = 0; s < 5; s++) begin
      rd = (s < 3) ? 1'b1 : 1'b0;
      raddr = (s == 0) ? 5'd5 : (s == 1) ? 5'd10 : 5'd31;
      step();
      for (int k = 0; k < 4; k++) begin
        lat_v[s][k] = dval[k];
        lat_d[s][k] = dout[k];
      end
    end
    idle();
    begin
      logic [4:0]  v0, v1;
      logic [15:0] d0x [5];
      logic [15:0] d1x [5];
      v0 = 5'b00111;  // bit s = valid after edge s+1, OUT_REG=0
      v1 = 5'b01110;  // OUT_REG=1
      d0x = '{16'hAA34, 16'h0A0A, 16'h1F1F, 16'h1F1F, 16'h1F1F};
      d1x = '{16'h2525, 16'hAA34, 16'h0A0A, 16'h1F1F, 16'h1F1F};
      for (int s = 0; s < 5; s++) begin
        for (int k = 0; k < 4; k++) begin
          check_lit("lat_valid", {31'h0, lat_v[s][k]}, {31'h0, (k < 2) ? v0[s] : v1[s]});
          check_lit("lat_dout", {16'h0, lat_d[s][k]}, {16'h0, (k < 2) ? d0x[s] : d1x[s]});
        end
      end
    end

    random_phase(1500);

    // Reset while outputs hold data.
    write1(5'd0, 16'h5A5A, 2'b11);
    read_lit("pre_reset", 5'd0, 16'h5A5A);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    for (int k = 0; k < 4; k++) begin
      check_lit("rst_dout", {16'h0, dout[k]}, 32'h0);
      check_lit("rst_valid", {31'h0, dval[k]}, 32'h0);
    end
    step();
    rst = 1'b0;
    for (int i = 0; i < 12; i++) step();
    // Sweep is at address 12: reset again mid-sweep.
    rst = 1'b1;
    model_reset();
    #1;
    check_lit("mid_sweep_dout", {16'h0, dout[2]}, 32'h0);
    check_lit("mid_sweep_valid", {31'h0, dval[2]}, 32'h0);
    step();
    rst = 1'b0;
    count_busy("busy_len_restart");
    read_lit("post_restart", 5'd0, 16'h0000);

    random_phase(300);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
